tmds_word_align: RTL and testbench

- Receive-side counterpart of the 10:1 TMDS output serializer.
- Sits directly after the 1:10 input deserializer, in the PCLK domain. It takes raw 10-bit words with unknown bit phase and finds the word boundary by hunting for TMDS control tokens.
- Outputs are the aligned 10-bit symbol stream, lock status and decoded control bits, for the downstream TMDS decoder.
- Bit order matches the transmitter: bit 0 of each word is the first bit on the wire.

---
 rtl/tmds_pkg.sv | 32 +++
 rtl/tmds_ctrl_detect.sv | 27 ++
 rtl/tmds_word_align.sv | 189 ++++++++++++++++++
 tb/tb_tmds_word_align.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, word width, aligner FSM states and
// small helpers used by the word aligner and the TMDS decoder.
package tmds_pkg;

  localparam int TMDS_W = 10;

  // The four DVI/HDMI control tokens, bit 0 first on the wire.
  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'h2AB;

  // Highest legal bit offset inside the 2-word window.
  localparam logic [3:0] OFFSET_LAST = 4'd9;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Offset advance with wrap 9 -> 0.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off >= OFFSET_LAST) ? 4'd0 : off + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_ctrl_detect.sv
// Combinational TMDS control-token detector: flags one of the four control
// tokens and decodes C1:C0 from it. Shared with the TMDS decoder.
module tmds_ctrl_detect
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] word,
  output logic              is_ctrl,
  output logic [1:0]        ctrl
);

  // Match the word against the four tokens; anything else is not control.
  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (word)
      TMDS_CTRL_00: ctrl = 2'b00;
      TMDS_CTRL_01: ctrl = 2'b01;
      TMDS_CTRL_10: ctrl = 2'b10;
      TMDS_CTRL_11: ctrl = 2'b11;
      default: begin
        is_ctrl = 1'b0;
        ctrl    = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/tmds_word_align.sv
// TMDS receive word aligner. Takes unaligned 10-bit words from the 1:10
// deserializer, hunts for control tokens across the ten bit offsets, and
// delivers the aligned symbol stream with lock status and decoded C1:C0.
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int MATCH_RUN    = 8,
  parameter int SEARCH_WORDS = 4096,
  parameter int LOSS_WORDS   = 65536
) (
  input  logic              PCLK,
  input  logic              RESET_N,
  input  logic [TMDS_W-1:0] RAW,
  input  logic              RAW_VALID,
  output logic [TMDS_W-1:0] DOUT,
  output logic              DOUT_VALID,
  output logic              IS_CTRL,
  output logic [1:0]        CTRL,
  output logic              LOCKED,
  output logic [3:0]        OFFSET,
  output logic              SLIP
);

  // Counter widths sized to their terminal values; run must reach MATCH_RUN.
  localparam int TIMER_W = cnt_w(SEARCH_WORDS - 1);
  localparam int LOSS_W  = cnt_w(LOSS_WORDS - 1);
  localparam int RUN_W   = cnt_w(MATCH_RUN);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEARCH_WORDS - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_WORDS - 1);
  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(MATCH_RUN);

  // Window bit 19 (RAW[9]) would only be needed at offset 10, which never
  // occurs, so the window stops at bit 18.
  localparam int WIN_W = 2 * TMDS_W - 1;

  align_state_t         state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [LOSS_W-1:0]    loss, loss_n;
  logic [RUN_W-1:0]     run, run_n;
  logic [3:0]           offset_n;
  logic                 locked_n;
  logic                 slip_n;

  logic [TMDS_W-1:0]    prev;
  logic [WIN_W-1:0]     window;
  logic [TMDS_W-1:0]    aligned;
  logic                 tok;
  logic [1:0]           tok_ctrl;

  // Select the 10-bit slice starting at the given offset.
  function automatic logic [TMDS_W-1:0] pick_word(input logic [WIN_W-1:0] w,
                                                  input logic [3:0] off);
    case (off)
      4'd0:    pick_word = w[9:0];
      4'd1:    pick_word = w[10:1];
      4'd2:    pick_word = w[11:2];
      4'd3:    pick_word = w[12:3];
      4'd4:    pick_word = w[13:4];
      4'd5:    pick_word = w[14:5];
      4'd6:    pick_word = w[15:6];
      4'd7:    pick_word = w[16:7];
      4'd8:    pick_word = w[17:8];
      4'd9:    pick_word = w[18:9];
      default: pick_word = w[9:0];
    endcase
  endfunction

  // Run-length increment that sticks at MATCH_RUN.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    run_sat_inc = (r >= RUN_MAX) ? RUN_MAX : r + RUN_W'(1);
  endfunction

  // Older word occupies the low half: its bit 0 arrived first on the wire.
  assign window  = {RAW[TMDS_W-2:0], prev};
  assign aligned = pick_word(window, OFFSET);

  tmds_ctrl_detect u_detect (
    .word    (aligned),
    .is_ctrl (tok),
    .ctrl    (tok_ctrl)
  );

  // Stage boundary: aligned word, token flag and C1:C0 registered together.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev       <= '0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      IS_CTRL    <= 1'b0;
      CTRL       <= 2'b00;
    end else begin
      DOUT_VALID <= RAW_VALID;
      if (RAW_VALID) begin
        prev    <= RAW;
        DOUT    <= aligned;
        IS_CTRL <= tok;
        if (tok) CTRL <= tok_ctrl;
      end
    end
  end

  // Alignment FSM next-state: only valid words move state or counters.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    loss_n   = loss;
    run_n    = run;
    offset_n = OFFSET;
    locked_n = LOCKED;
    slip_n   = 1'b0;
    if (RAW_VALID) begin
      case (state)
        ST_SEARCH: begin
          if (tok) begin
            state_n = ST_VERIFY;
            run_n   = RUN_W'(1);
            timer_n = '0;
          end else if (timer == TIMER_LAST) begin
            timer_n  = '0;
            offset_n = next_offset(OFFSET);
            slip_n   = 1'b1;
          end else begin
            timer_n = timer + TIMER_W'(1);
          end
        end
        ST_VERIFY: begin
          if (tok) begin
            run_n = run_sat_inc(run);
            if (run_sat_inc(run) == RUN_MAX) begin
              state_n  = ST_LOCKED;
              locked_n = 1'b1;
              loss_n   = '0;
            end
          end else begin
            // A broken run restarts the hunt at the same offset.
            state_n = ST_SEARCH;
            run_n   = '0;
            timer_n = '0;
          end
        end
        ST_LOCKED: begin
          if (tok) begin
            loss_n = '0;
          end else if (loss == LOSS_LAST) begin
            state_n  = ST_SEARCH;
            locked_n = 1'b0;
            offset_n = next_offset(OFFSET);
            slip_n   = 1'b1;
            run_n    = '0;
            timer_n  = '0;
            loss_n   = '0;
          end else begin
            loss_n = loss + LOSS_W'(1);
          end
        end
        default: begin
          state_n  = ST_SEARCH;
          run_n    = '0;
          timer_n  = '0;
          loss_n   = '0;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and status outputs change on the same edge.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_SEARCH;
      timer  <= '0;
      loss   <= '0;
      run    <= '0;
      OFFSET <= '0;
      LOCKED <= 1'b0;
      SLIP   <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      loss   <= loss_n;
      run    <= run_n;
      OFFSET <= offset_n;
      LOCKED <= locked_n;
      SLIP   <= slip_n;
    end
  end

endmodule

// File: tb/tb_tmds_word_align.sv
// Directed bench for tmds_word_align with SEARCH_WORDS=16, MATCH_RUN=8,
// LOSS_WORDS=64. At offset 0 the aligned word is the previous RAW word, so
// after reset the first valid word only primes the window: an aligned token
// stream locks on its 9th valid word (8 tokens).
module tb_tmds_word_align;

  logic       PCLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [9:0] RAW = '0;
  logic       RAW_VALID = 1'b0;
  logic [9:0] DOUT;
  logic       DOUT_VALID;
  logic       IS_CTRL;
  logic [1:0] CTRL;
  logic       LOCKED;
  logic [3:0] OFFSET;
  logic       SLIP;

  int total = 0;
  int bad = 0;

  always #5 PCLK = ~PCLK;

  tmds_word_align #(
    .MATCH_RUN    (8),
    .SEARCH_WORDS (16),
    .LOSS_WORDS   (64)
  ) dut (
    .PCLK       (PCLK),
    .RESET_N    (RESET_N),
    .RAW        (RAW),
    .RAW_VALID  (RAW_VALID),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .IS_CTRL    (IS_CTRL),
    .CTRL       (CTRL),
    .LOCKED     (LOCKED),
    .OFFSET     (OFFSET),
    .SLIP       (SLIP)
  );

  // Raw deserializer word for a repeating token whose boundary sits k bits in.
  function automatic logic [9:0] rot_raw(input logic [9:0] t, input int k);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = t[(j + 10 - k) % 10];
    return r;
  endfunction

  task automatic step(input logic [9:0] r, input logic v);
    RAW = r;
    RAW_VALID = v;
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    RAW = '0;
    RAW_VALID = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    do_reset();
    for (int w = 0; w < 9; w++) step(10'h354, 1'b1);
    total++;
    if (LOCKED !== 1'b1 || DOUT !== 10'h354) begin
      bad++;
      $display("FAIL reset_precond: LOCKED=%0b DOUT=%h, want LOCKED=1 DOUT=354", LOCKED, DOUT);
    end
    #2 RESET_N = 1'b0;
    #1 outs = {DOUT, DOUT_VALID, IS_CTRL, CTRL, LOCKED, OFFSET, SLIP};
    total++;
    if (outs !== 20'h0) begin
      bad++;
      $display("FAIL reset_async: outs=%h, want 00000", outs);
    end
    RAW_VALID = 1'b0;
    @(posedge PCLK);
    #1 RESET_N = 1'b1;
    repeat (3) step(10'h354, 1'b0);
    outs = {DOUT, DOUT_VALID, IS_CTRL, CTRL, LOCKED, OFFSET, SLIP};
    total++;
    if (outs !== 20'h0) begin
      bad++;
      $display("FAIL reset_release_idle: outs=%h, want 00000", outs);
    end
    total++;
    if (OFFSET !== 4'd0) begin
      bad++;
      $display("FAIL reset_offset: got=%0d want=0", OFFSET);
    end
  endtask

  task automatic test_aligned();
    int slips;
    slips = 0;
    do_reset();
    for (int w = 1; w <= 9; w++) begin
      step(10'h354, 1'b1);
      if (SLIP) slips++;
      if (w == 1) begin
        total++;
        if (DOUT_VALID !== 1'b1 || DOUT !== 10'h000) begin
          bad++;
          $display("FAIL aligned_first_word: DOUT_VALID=%0b DOUT=%h, want 1 000", DOUT_VALID, DOUT);
        end
      end
      if (w == 8) begin
        total++;
        if (LOCKED !== 1'b0) begin
          bad++;
          $display("FAIL aligned_early_lock: got=%0b want=0", LOCKED);
        end
      end
    end
    total++;
    if (LOCKED !== 1'b1) begin
      bad++;
      $display("FAIL aligned_lock: got=%0b want=1", LOCKED);
    end
    total++;
    if (OFFSET !== 4'd0 || slips != 0) begin
      bad++;
      $display("FAIL aligned_no_slip: OFFSET=%0d slips=%0d, want 0 0", OFFSET, slips);
    end
    total++;
    if (DOUT !== 10'h354 || IS_CTRL !== 1'b1 || CTRL !== 2'b00) begin
      bad++;
      $display("FAIL aligned_data: DOUT=%h IS_CTRL=%0b CTRL=%0d, want 354 1 0", DOUT, IS_CTRL, CTRL);
    end
    step(10'h354, 1'b0);
    total++;
    if (DOUT_VALID !== 1'b0 || DOUT !== 10'h354) begin
      bad++;
      $display("FAIL aligned_valid_drop: DOUT_VALID=%0b DOUT=%h, want 0 354", DOUT_VALID, DOUT);
    end
    step(10'h354, 1'b1);
    total++;
    if (DOUT_VALID !== 1'b1) begin
      bad++;
      $display("FAIL aligned_valid_follow: got=%0b want=1", DOUT_VALID);
    end
  endtask

  task automatic test_misaligned();
    int nslip;
    int slip_at[4];
    int lock_word;
    logic [9:0] r;
    nslip = 0;
    lock_word = 0;
    for (int i = 0; i < 4; i++) slip_at[i] = 0;
    r = rot_raw(10'h2AB, 3);
    do_reset();
    for (int w = 1; w <= 70; w++) begin
      step(r, 1'b1);
      if (SLIP) begin
        if (nslip < 4) slip_at[nslip] = w;
        nslip++;
      end
      if (LOCKED && lock_word == 0) lock_word = w;
    end
    total++;
    if (nslip != 3) begin
      bad++;
      $display("FAIL mis_slip_count: got=%0d want=3", nslip);
    end
    total++;
    if (slip_at[0] != 16 || slip_at[1] != 32 || slip_at[2] != 48) begin
      bad++;
      $display("FAIL mis_slip_spacing: got=%0d,%0d,%0d want=16,32,48", slip_at[0], slip_at[1], slip_at[2]);
    end
    total++;
    if (lock_word != 56) begin
      bad++;
      $display("FAIL mis_lock_word: got=%0d want=56", lock_word);
    end
    total++;
    if (OFFSET !== 4'd3 || LOCKED !== 1'b1) begin
      bad++;
      $display("FAIL mis_offset: OFFSET=%0d LOCKED=%0b, want 3 1", OFFSET, LOCKED);
    end
    total++;
    if (DOUT !== 10'h2AB || CTRL !== 2'b11 || IS_CTRL !== 1'b1) begin
      bad++;
      $display("FAIL mis_data: DOUT=%h CTRL=%0d IS_CTRL=%0b, want 2ab 3 1", DOUT, CTRL, IS_CTRL);
    end
  endtask

  task automatic test_broken_run();
    int slips;
    int lock_word;
    slips = 0;
    lock_word = 0;
    do_reset();
    for (int w = 1; w <= 20; w++) begin
      step((w == 6) ? 10'h1F0 : 10'h0AB, 1'b1);
      if (SLIP) slips++;
      if (LOCKED && lock_word == 0) lock_word = w;
      if (w == 6) begin
        total++;
        if (CTRL !== 2'b01 || IS_CTRL !== 1'b1) begin
          bad++;
          $display("FAIL broken_token_ctrl: CTRL=%0d IS_CTRL=%0b, want 1 1", CTRL, IS_CTRL);
        end
      end
      if (w == 7) begin
        total++;
        if (DOUT !== 10'h1F0 || IS_CTRL !== 1'b0 || CTRL !== 2'b01) begin
          bad++;
          $display("FAIL broken_ctrl_hold: DOUT=%h IS_CTRL=%0b CTRL=%0d, want 1f0 0 1", DOUT, IS_CTRL, CTRL);
        end
      end
    end
    total++;
    if (lock_word != 15) begin
      bad++;
      $display("FAIL broken_relock_word: got=%0d want=15", lock_word);
    end
    total++;
    if (slips != 0 || OFFSET !== 4'd0) begin
      bad++;
      $display("FAIL broken_no_slip: slips=%0d OFFSET=%0d, want 0 0", slips, OFFSET);
    end
  endtask

  task automatic test_loss();
    int slips;
    int lock_word;
    logic [9:0] r;
    // Offset 0: 63 aligned non-tokens keep lock, the 64th drops it.
    slips = 0;
    do_reset();
    repeat (9) step(10'h354, 1'b1);
    for (int w = 1; w <= 64; w++) begin
      step(10'h000, 1'b1);
      if (SLIP) slips++;
    end
    total++;
    if (LOCKED !== 1'b1 || slips != 0) begin
      bad++;
      $display("FAIL loss_hold_63: LOCKED=%0b slips=%0d, want 1 0", LOCKED, slips);
    end
    step(10'h000, 1'b1);
    total++;
    if (LOCKED !== 1'b0 || SLIP !== 1'b1 || OFFSET !== 4'd1) begin
      bad++;
      $display("FAIL loss_drop: LOCKED=%0b SLIP=%0b OFFSET=%0d, want 0 1 1", LOCKED, SLIP, OFFSET);
    end
    step(10'h000, 1'b1);
    total++;
    if (SLIP !== 1'b0) begin
      bad++;
      $display("FAIL loss_slip_pulse: got=%0b want=0", SLIP);
    end
    // A token as the 63rd aligned word resets the loss count.
    slips = 0;
    do_reset();
    repeat (9) step(10'h354, 1'b1);
    for (int w = 1; w <= 65; w++) begin
      step((w == 63) ? 10'h354 : 10'h000, 1'b1);
      if (SLIP) slips++;
    end
    total++;
    if (LOCKED !== 1'b1 || slips != 0) begin
      bad++;
      $display("FAIL loss_token_keeps: LOCKED=%0b slips=%0d, want 1 0", LOCKED, slips);
    end
    // Offset 9: loss of lock wraps the offset back to 0.
    lock_word = 0;
    r = rot_raw(10'h2AB, 9);
    do_reset();
    for (int w = 1; w <= 160; w++) begin
      step(r, 1'b1);
      if (LOCKED && lock_word == 0) lock_word = w;
    end
    total++;
    if (lock_word != 152 || OFFSET !== 4'd9) begin
      bad++;
      $display("FAIL wrap_lock: word=%0d OFFSET=%0d, want 152 9", lock_word, OFFSET);
    end
    repeat (63) step(10'h000, 1'b1);
    total++;
    if (LOCKED !== 1'b1) begin
      bad++;
      $display("FAIL wrap_hold_63: got=%0b want=1", LOCKED);
    end
    step(10'h000, 1'b1);
    total++;
    if (LOCKED !== 1'b0 || SLIP !== 1'b1 || OFFSET !== 4'd0) begin
      bad++;
      $display("FAIL wrap_drop: LOCKED=%0b SLIP=%0b OFFSET=%0d, want 0 1 0", LOCKED, SLIP, OFFSET);
    end
  endtask

  task automatic test_gapped();
    int clk_n;
    int lock_clk;
    logic [9:0] held;
    clk_n = 0;
    lock_clk = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(10'h354, 1'b1);
      clk_n++;
      if (LOCKED && lock_clk == 0) lock_clk = clk_n;
      held = DOUT;
      step(10'h1F0, 1'b0);
      clk_n++;
      if (LOCKED && lock_clk == 0) lock_clk = clk_n;
      total++;
      if (DOUT_VALID !== 1'b0 || DOUT !== held) begin
        bad++;
        $display("FAIL gap_hold_%0d: DOUT_VALID=%0b DOUT=%h, want 0 %h", i, DOUT_VALID, DOUT, held);
      end
    end
    total++;
    if (lock_clk != 17) begin
      bad++;
      $display("FAIL gap_lock_clock: got=%0d want=17", lock_clk);
    end
    total++;
    if (DOUT !== 10'h354 || OFFSET !== 4'd0) begin
      bad++;
      $display("FAIL gap_data: DOUT=%h OFFSET=%0d, want 354 0", DOUT, OFFSET);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_broken_run();
    test_loss();
    test_gapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
